// File: rtl/tm_rule_table.sv
// Transition-rule store indexed by {state, symbol}. Synchronous read with one cycle latency, and a sweep that zeroes the table after reset or clear.
// Optional per-entry valid tracking with an out_miss output: `define TM_RULE_VALID_TRACK_EN.
module tm_rule_table #(
  parameter int STATE_W = 14,
  parameter int SYM_W   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  output logic               busy,
  input  logic               wr_en,
  input  logic [STATE_W-1:0] wr_state,
  input  logic [SYM_W-1:0]   wr_sym,
  input  logic [STATE_W-1:0] wr_next,
  input  logic [SYM_W-1:0]   wr_wsym,
  input  logic [1:0]         wr_move,
  input  logic               lk_valid,
  output logic               lk_ready,
  input  logic [STATE_W-1:0] lk_state,
  input  logic [SYM_W-1:0]   lk_sym,
  output logic               out_valid,
  output logic [STATE_W-1:0] out_next,
  output logic [SYM_W-1:0]   out_wsym,
  output logic [1:0]         out_move,
`ifdef TM_RULE_VALID_TRACK_EN
  output logic               out_miss,
`endif
  output logic               out_halt
);

  localparam int IDX_W = STATE_W + SYM_W;
  localparam int DEPTH = 1 << IDX_W;
  localparam int CNT_W = IDX_W + 1;
`ifdef TM_RULE_VALID_TRACK_EN
  localparam int ENT_W = STATE_W + SYM_W + 3;
`else
  localparam int ENT_W = STATE_W + SYM_W + 2;
`endif

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [ENT_W-1:0]   r_mem [DEPTH];

  logic               w_mem_we;
  logic [IDX_W-1:0]   w_mem_idx;
  logic [ENT_W-1:0]   w_mem_dat;
  logic [ENT_W-1:0]   w_wr_dat;
  logic               w_sweep_last;
  logic               w_lk_acc;
  logic [ENT_W-1:0]   w_rd;
  logic [1:0]         w_rd_move;

`ifdef TM_RULE_VALID_TRACK_EN
  assign w_wr_dat = {1'b1, wr_next, wr_wsym, wr_move};
`else
  assign w_wr_dat = {wr_next, wr_wsym, wr_move};
`endif

  // Counter carries one extra bit so the terminal compare at DEPTH-1 never aliases.
  assign w_sweep_last = (r_cnt == CNT_W'(DEPTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    w_mem_idx   = {wr_state, wr_sym};
    w_mem_dat   = w_wr_dat;
    case (r_state)
      ST_SWEEP: begin
        w_mem_we  = 1'b1;
        w_mem_idx = r_cnt[IDX_W-1:0];
        w_mem_dat = '0;
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_sweep_last) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear) begin
          w_state_nxt = ST_SWEEP;
          w_cnt_nxt   = '0;
        end else if (wr_en) begin
          w_mem_we = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_SWEEP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SWEEP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign busy     = (r_state == ST_SWEEP);
  assign lk_ready = !busy;
  assign w_lk_acc = lk_valid && lk_ready;
  // Nonblocking write plus read of the same array gives read-first behaviour.
  assign w_rd     = r_mem[{lk_state, lk_sym}];

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_dat;
  end

`ifdef TM_RULE_VALID_TRACK_EN
  assign w_rd_move = w_rd[ENT_W-1] ? w_rd[1:0] : 2'b11;
`else
  assign w_rd_move = w_rd[1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_next  <= '0;
      out_wsym  <= '0;
      out_move  <= 2'b00;
      out_halt  <= 1'b0;
`ifdef TM_RULE_VALID_TRACK_EN
      out_miss  <= 1'b0;
`endif
    end else begin
      out_valid <= w_lk_acc;
      if (w_lk_acc) begin
        out_next <= w_rd[2+SYM_W +: STATE_W];
        out_wsym <= w_rd[2 +: SYM_W];
        out_move <= w_rd_move;
        out_halt <= (w_rd_move == 2'b11);
`ifdef TM_RULE_VALID_TRACK_EN
        out_miss <= !w_rd[ENT_W-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_tm_rule_table.sv
// Bench for tm_rule_table at STATE_W=3, SYM_W=1: directed table, clear/reset sequences, randomized run against an array model.
module tb_tm_rule_table;

  localparam int D = 16;
`ifdef TM_RULE_VALID_TRACK_EN
  localparam bit TRK = 1'b1;
`else
  localparam bit TRK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, clear, busy, wr_en, lk_valid, lk_ready;
  logic [2:0] wr_state, wr_next, lk_state, out_next;
  logic       wr_sym, wr_wsym, lk_sym, out_wsym;
  logic [1:0] wr_move, out_move;
  logic       out_valid, out_halt;
  logic       miss_obs;
`ifdef TM_RULE_VALID_TRACK_EN
  logic       out_miss;
  assign miss_obs = out_miss;
`else
  assign miss_obs = 1'b0;
`endif

  tm_rule_table #(.STATE_W(3), .SYM_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy),
    .wr_en(wr_en), .wr_state(wr_state), .wr_sym(wr_sym),
    .wr_next(wr_next), .wr_wsym(wr_wsym), .wr_move(wr_move),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_state(lk_state), .lk_sym(lk_sym),
    .out_valid(out_valid), .out_next(out_next), .out_wsym(out_wsym),
    .out_move(out_move),
`ifdef TM_RULE_VALID_TRACK_EN
    .out_miss(out_miss),
`endif
    .out_halt(out_halt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit wr; int ws; int wy; int wn; int ww; int wm;
    bit lk; int ls; int ly;
    bit ev; int en; int ew; int em; bit emiss;
  } vec_t;
  vec_t vecs[8];

  // Reference model: the rule table as plain arrays, with the sweep as a countdown.
  bit m_vld [D];
  int m_next[D], m_wsym[D], m_move[D];
  int m_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string n, input bit v, input int nx, input int ws,
                           input int mv, input bit ms);
    chk({n, ".valid"}, 32'(out_valid), 32'(v));
    chk({n, ".next"},  32'(out_next),  nx);
    chk({n, ".wsym"},  32'(out_wsym),  ws);
    chk({n, ".move"},  32'(out_move),  mv);
    chk({n, ".halt"},  32'(out_halt),  32'(mv == 3));
    if (TRK) chk({n, ".miss"}, 32'(miss_obs), 32'(ms));
  endtask

  // What a lookup of idx should return from the model.
  task automatic model_rd(input int idx, output int nx, output int ws, output int mv, output bit ms);
    ms = TRK && !m_vld[idx];
    nx = m_next[idx];
    ws = m_wsym[idx];
    mv = ms ? 3 : m_move[idx];
  endtask

  task automatic wait_idle(input string n, input int exp_cycles);
    int cnt = 0;
    while (busy && cnt < 100) begin
      chk({n, ".rdy_lo"}, 32'(lk_ready), 32'd0);
      tick();
      cnt++;
      chk({n, ".no_out"}, 32'(out_valid), 32'd0);
    end
    chk({n, ".busy_cycles"}, cnt, exp_cycles);
    chk({n, ".rdy_hi"}, 32'(lk_ready), 32'd1);
  endtask

  task automatic idle_inputs();
    clear = 0; wr_en = 0; lk_valid = 0;
  endtask

  task automatic do_write(input int s, input int y, input int n, input int w, input int m);
    wr_en = 1; wr_state = 3'(s); wr_sym = 1'(y); wr_next = 3'(n); wr_wsym = 1'(w); wr_move = 2'(m);
  endtask

  task automatic do_lookup(input int s, input int y);
    lk_valid = 1; lk_state = 3'(s); lk_sym = 1'(y);
  endtask

  initial begin
    int nx, ws, mv; bit ms;
    int e_nx, e_ws, e_mv; bit e_ms, e_v;
    bit idle_pre, clr;
    int idx;

    rst_n = 0; idle_inputs();
    wr_state = 0; wr_sym = 0; wr_next = 0; wr_wsym = 0; wr_move = 0; lk_state = 0; lk_sym = 0;
    #12;
    chk("rst.busy", 32'(busy), 1);
    chk("rst.rdy", 32'(lk_ready), 0);
    check_out("rst", 0, 0, 0, 0, 0);
    @(posedge clk); #1; rst_n = 1;
    wait_idle("init", D);

    vecs[0] = '{1,5,1,3,0,1, 0,0,0, 0,0,0,0,0};
    vecs[1] = '{0,0,0,0,0,0, 1,5,1, 1,3,0,1,0};
    vecs[2] = '{1,2,0,6,1,3, 1,2,0, 1,0,0,(TRK ? 3 : 0),TRK};
    vecs[3] = '{0,0,0,0,0,0, 1,2,0, 1,6,1,3,0};
    vecs[4] = '{0,0,0,0,0,0, 1,5,1, 1,3,0,1,0};
    vecs[5] = '{0,0,0,0,0,0, 1,2,0, 1,6,1,3,0};
    vecs[6] = '{0,0,0,0,0,0, 1,5,1, 1,3,0,1,0};
    vecs[7] = '{0,0,0,0,0,0, 0,0,0, 0,3,0,1,0};
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      if (vecs[i].wr) do_write(vecs[i].ws, vecs[i].wy, vecs[i].wn, vecs[i].ww, vecs[i].wm);
      if (vecs[i].lk) do_lookup(vecs[i].ls, vecs[i].ly);
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].en, vecs[i].ew, vecs[i].em, vecs[i].emiss);
    end

    // Lookup accepted alongside clear returns pre-clear data; a write in that cycle is dropped.
    idle_inputs(); clear = 1; do_lookup(5, 1); do_write(5, 1, 7, 1, 2);
    tick();
    check_out("clr_lk", 1, 3, 0, 1, 0);
    chk("clr.busy", 32'(busy), 1);
    idle_inputs(); do_lookup(5, 1); do_write(4, 0, 7, 1, 2);
    wait_idle("clr", D);
    idle_inputs(); do_lookup(5, 1);
    tick();
    check_out("post_clr51", 1, 0, 0, TRK ? 3 : 0, TRK);
    do_lookup(4, 0);
    tick();
    check_out("post_clr40", 1, 0, 0, TRK ? 3 : 0, TRK);

    // Reset in the middle of a sweep.
    idle_inputs(); do_write(1, 1, 5, 1, 2);
    tick();
    idle_inputs(); do_lookup(1, 1);
    tick();
    check_out("pre_rst", 1, 5, 1, 2, 0);
    idle_inputs(); clear = 1;
    tick();
    idle_inputs();
    repeat (7) tick();
    chk("mid.busy", 32'(busy), 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst.busy", 32'(busy), 1);
    chk("mid_rst.rdy", 32'(lk_ready), 0);
    check_out("mid_rst", 0, 0, 0, 0, 0);
    tick(); rst_n = 1;
    wait_idle("mid_rst", D);

    for (int i = 0; i < D; i++) begin
      m_vld[i] = 0; m_next[i] = 0; m_wsym[i] = 0; m_move[i] = 0;
    end
    m_left = 0;
    e_nx = 0; e_ws = 0; e_mv = 0; e_ms = 0;
    for (int c = 0; c < 600; c++) begin
      clr = ($urandom_range(0, 39) == 0);
      clear = clr;
      wr_en = 1'($urandom_range(0, 1));
      wr_state = 3'($urandom); wr_sym = 1'($urandom);
      wr_next = 3'($urandom); wr_wsym = 1'($urandom); wr_move = 2'($urandom);
      lk_valid = ($urandom_range(0, 3) != 0);
      lk_state = 3'($urandom); lk_sym = 1'($urandom);
      idle_pre = (m_left == 0);
      e_v = lk_valid && idle_pre;
      if (e_v) begin
        model_rd({lk_state, lk_sym}, nx, ws, mv, ms);
        e_nx = nx; e_ws = ws; e_mv = mv; e_ms = ms;
      end
      if (wr_en && idle_pre && !clr) begin
        idx = {wr_state, wr_sym};
        m_vld[idx] = 1; m_next[idx] = wr_next; m_wsym[idx] = wr_wsym; m_move[idx] = wr_move;
      end
      tick();
      if (m_left > 0) m_left--;
      if (clr && idle_pre) begin
        m_left = D;
        for (int i = 0; i < D; i++) begin
          m_vld[i] = 0; m_next[i] = 0; m_wsym[i] = 0; m_move[i] = 0;
        end
      end
      chk("rnd.busy", 32'(busy), 32'(m_left != 0));
      chk("rnd.rdy", 32'(lk_ready), 32'(m_left == 0));
      check_out($sformatf("rnd%0d", c), e_v, e_nx, e_ws, e_mv, e_ms);
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
